// File: rtl/vga_pkg.sv
// Shared VGA constants: default timing, sync polarities and the bounce-box colours.
package vga_pkg;

    localparam int unsigned DEF_H_PIXELS = 640;
    localparam int unsigned DEF_V_PIXELS = 480;
    localparam logic        DEF_H_POL    = 1'b0;
    localparam logic        DEF_V_POL    = 1'b0;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    // Bit 2 = red, bit 1 = green, bit 0 = blue; index 0 is grey so the box never vanishes.
    localparam rgb_t PALETTE [8] = '{
        '{r: 8'h80, g: 8'h80, b: 8'h80},
        '{r: 8'h00, g: 8'h00, b: 8'hFF},
        '{r: 8'h00, g: 8'hFF, b: 8'h00},
        '{r: 8'h00, g: 8'hFF, b: 8'hFF},
        '{r: 8'hFF, g: 8'h00, b: 8'h00},
        '{r: 8'hFF, g: 8'h00, b: 8'hFF},
        '{r: 8'hFF, g: 8'hFF, b: 8'h00},
        '{r: 8'hFF, g: 8'hFF, b: 8'hFF}
    };

    localparam rgb_t GRID_RGB = '{r: 8'h40, g: 8'h40, b: 8'h40};
    localparam rgb_t BG_RGB   = '{r: 8'h00, g: 8'h00, b: 8'h30};

endpackage

// File: rtl/bounce_axis.sv
// One axis of the bouncing box: position, travel direction and wall-hit detection.
module bounce_axis #(
    parameter int unsigned LIMIT = 576,
    parameter int unsigned STEP  = 2
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        tick,
    input  logic        hold,
    output logic [31:0] pos,
    output logic        hit
);

    logic        dir;
    logic [31:0] pos_next;
    logic        dir_next;

    // Next position: move by STEP, or clamp to the wall and turn around.
    always_comb begin
        pos_next = pos;
        dir_next = dir;
        hit      = 1'b0;
        if (tick && !hold) begin
            if (dir) begin
                if (pos + STEP > LIMIT) begin
                    pos_next = LIMIT;
                    dir_next = 1'b0;
                    hit      = 1'b1;
                end else begin
                    pos_next = pos + STEP;
                end
            end else begin
                if (pos < STEP) begin
                    pos_next = '0;
                    dir_next = 1'b1;
                    hit      = 1'b1;
                end else begin
                    pos_next = pos - STEP;
                end
            end
        end
    end

    // Position/direction state; restart at the origin moving increasing.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            pos <= '0;
            dir <= 1'b1;
        end else begin
            pos <= pos_next;
            dir <= dir_next;
        end
    end

endmodule

// File: rtl/vga_bounce_generator.sv
// Pixel source drawing a bouncing, colour-cycling box over a grid; 2-stage aligned pipeline.
module vga_bounce_generator
    import vga_pkg::*;
#(
    parameter int unsigned H_PIXELS = DEF_H_PIXELS,
    parameter int unsigned V_PIXELS = DEF_V_PIXELS,
    parameter int unsigned BOX_SIZE = 64,
    parameter int unsigned STEP     = 2,
    parameter logic        H_POL    = DEF_H_POL,
    parameter logic        V_POL    = DEF_V_POL
) (
    input  logic        pixel_clk,
    input  logic        reset,
    input  logic        disp_ena,
    input  logic [31:0] row,
    input  logic [31:0] column,
    input  logic        h_sync_in,
    input  logic        v_sync_in,
    input  logic        n_blank_in,
    input  logic        n_sync_in,
    input  logic        freeze,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        h_sync,
    output logic        v_sync,
    output logic        n_blank,
    output logic        n_sync
);

    logic        v_sync_prev;
    logic        armed;
    logic        tick;
    logic [31:0] box_x;
    logic [31:0] box_y;
    logic        hit_x;
    logic        hit_y;
    logic [2:0]  colour_idx;
    logic        in_box;
    logic        on_grid;
    logic        s1_disp_ena;
    logic        s1_in_box;
    logic        s1_on_grid;
    logic        s1_h_sync;
    logic        s1_v_sync;
    logic        s1_n_blank;
    logic        s1_n_sync;
    rgb_t        pixel;

    // armed is low for the first cycle after reset so a v_sync already active at
    // release is not mistaken for a leading edge.
    assign tick = armed && (v_sync_prev != V_POL) && (v_sync_in == V_POL);

    // Frame-tick edge register.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            v_sync_prev <= ~V_POL;
            armed       <= 1'b0;
        end else begin
            v_sync_prev <= v_sync_in;
            armed       <= 1'b1;
        end
    end

    bounce_axis #(
        .LIMIT (H_PIXELS - BOX_SIZE),
        .STEP  (STEP)
    ) u_axis_x (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .tick      (tick),
        .hold      (freeze),
        .pos       (box_x),
        .hit       (hit_x)
    );

    bounce_axis #(
        .LIMIT (V_PIXELS - BOX_SIZE),
        .STEP  (STEP)
    ) u_axis_y (
        .pixel_clk (pixel_clk),
        .reset     (reset),
        .tick      (tick),
        .hold      (freeze),
        .pos       (box_y),
        .hit       (hit_y)
    );

    // Colour advances once per bouncing tick, even when both axes hit (corner).
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            colour_idx <= '0;
        end else if (hit_x || hit_y) begin
            colour_idx <= colour_idx + 3'd1;
        end
    end

    assign in_box  = disp_ena
                     && (column >= box_x) && (column < box_x + BOX_SIZE)
                     && (row >= box_y) && (row < box_y + BOX_SIZE);
    assign on_grid = disp_ena && ((column[5:0] == 6'd0) || (row[5:0] == 6'd0));

    // Stage 1: pixel classification plus strobe delay.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            s1_disp_ena <= 1'b0;
            s1_in_box   <= 1'b0;
            s1_on_grid  <= 1'b0;
            s1_h_sync   <= ~H_POL;
            s1_v_sync   <= ~V_POL;
            s1_n_blank  <= 1'b0;
            s1_n_sync   <= 1'b0;
        end else begin
            s1_disp_ena <= disp_ena;
            s1_in_box   <= in_box;
            s1_on_grid  <= on_grid;
            s1_h_sync   <= h_sync_in;
            s1_v_sync   <= v_sync_in;
            s1_n_blank  <= n_blank_in;
            s1_n_sync   <= n_sync_in;
        end
    end

    // Colour selection by priority: blanking, box, grid, background.
    always_comb begin
        pixel = '0;
        if (!s1_disp_ena) begin
            pixel = '0;
        end else if (s1_in_box) begin
            pixel = PALETTE[colour_idx];
        end else if (s1_on_grid) begin
            pixel = GRID_RGB;
        end else begin
            pixel = BG_RGB;
        end
    end

    // Stage 2: registered RGB and strobes leave together.
    always_ff @(posedge pixel_clk) begin
        if (reset) begin
            red     <= '0;
            green   <= '0;
            blue    <= '0;
            h_sync  <= ~H_POL;
            v_sync  <= ~V_POL;
            n_blank <= 1'b0;
            n_sync  <= 1'b0;
        end else begin
            red     <= pixel.r;
            green   <= pixel.g;
            blue    <= pixel.b;
            h_sync  <= s1_h_sync;
            v_sync  <= s1_v_sync;
            n_blank <= s1_n_blank;
            n_sync  <= s1_n_sync;
        end
    end

endmodule
